// File: rtl/counter_seq_ctrl.sv
// Purpose: sequences a 4-bit presettable counter stage (load, enable, terminal detect) as an interval timer.
// Latency: LOAD one cycle after start, done 2 + (2^CNT_W - preset) cycles after start; outputs registered.
// Backpressure: hold pauses the counter in RUN; stop aborts to IDLE on the next edge from any busy state.
//
// Ports:
//   CLK, CLR_n      clock, asynchronous active-low reset
//   start, stop     begin a run (IDLE only) / abort (any busy state, wins over start)
//   periodic        reload and repeat after each interval when high (sampled in DONE)
//   hold            pause counting while high (RUN only)
//   preset, Q       start value (latched on accepted start) / counter stage output
//   D, LOAD_n       parallel data and active-low load to the counter stage
//   ENP, ENT        counter enables (parallel / trickle)
//   busy, done      not-IDLE flag / one-cycle pulse per completed interval
//   pcnt            completed intervals since last start, saturating
module counter_seq_ctrl #(
  parameter int CNT_W  = 4,
  parameter int PCNT_W = 8
) (
  input  logic              CLK,
  input  logic              CLR_n,
  input  logic              start,
  input  logic              stop,
  input  logic              periodic,
  input  logic              hold,
  input  logic [CNT_W-1:0]  preset,
  input  logic [CNT_W-1:0]  Q,
  output logic [CNT_W-1:0]  D,
  output logic              LOAD_n,
  output logic              ENP,
  output logic              ENT,
  output logic              busy,
  output logic              done,
  output logic [PCNT_W-1:0] pcnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] preset_q;
  logic             ent_q;
  logic             terminal;

  // Terminal only when the counter will actually wrap on this edge, i.e. not paused.
  assign terminal = (Q == {CNT_W{1'b1}}) && !hold;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && !stop) state_nxt = LOAD;
      LOAD: state_nxt = stop ? IDLE : RUN;
      RUN: begin
        if (stop)          state_nxt = IDLE;
        else if (terminal) state_nxt = DONE;
      end
      DONE: state_nxt = (periodic && !stop) ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State and all control outputs are registered, decoded from the next state.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state    <= IDLE;
      preset_q <= '0;
      LOAD_n   <= 1'b1;
      ent_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pcnt     <= '0;
    end else begin
      state  <= state_nxt;
      LOAD_n <= (state_nxt != LOAD);
      ent_q  <= (state_nxt == RUN);
      busy   <= (state_nxt != IDLE);
      done   <= (state_nxt == DONE);
      if (state == IDLE && state_nxt == LOAD) begin
        preset_q <= preset;
        pcnt     <= '0;
      end else if (state_nxt == DONE && pcnt != {PCNT_W{1'b1}}) begin
        // DONE is only ever entered from RUN, so this fires once per interval.
        pcnt <= pcnt + 1'b1;
      end
    end
  end

  assign D   = preset_q;
  assign ENT = ent_q;
  // ENP follows hold within the same cycle so the counter pauses on exactly
  // the edges where the FSM also withholds the terminal decision.
  assign ENP = ent_q & ~hold;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
module tb_counter_seq_ctrl;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;
  localparam int P_DONE = 3;

  logic       CLK = 1'b0;
  logic       CLR_n;
  logic       start, stop, periodic, hold;
  logic [3:0] preset;

  logic [3:0] q_a, d_a, q_b, d_b;
  logic       load_n_a, enp_a, ent_a, busy_a, done_a;
  logic       load_n_b, enp_b, ent_b, busy_b, done_b;
  logic [7:0] pcnt_a;
  logic [1:0] pcnt_b;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0;
  int n_done, first_done, last_done;

  // Reference model state
  int m_phase, m_preset, m_pcnt, m_rem;

  always #5 CLK = ~CLK;

  counter_seq_ctrl #(.CNT_W(4), .PCNT_W(8)) dut_a (
    .CLK(CLK), .CLR_n(CLR_n), .start(start), .stop(stop), .periodic(periodic),
    .hold(hold), .preset(preset), .Q(q_a), .D(d_a), .LOAD_n(load_n_a),
    .ENP(enp_a), .ENT(ent_a), .busy(busy_a), .done(done_a), .pcnt(pcnt_a)
  );

  counter_seq_ctrl #(.CNT_W(4), .PCNT_W(2)) dut_b (
    .CLK(CLK), .CLR_n(CLR_n), .start(start), .stop(stop), .periodic(periodic),
    .hold(hold), .preset(preset), .Q(q_b), .D(d_b), .LOAD_n(load_n_b),
    .ENP(enp_b), .ENT(ent_b), .busy(busy_b), .done(done_b), .pcnt(pcnt_b)
  );

  // Presettable 4-bit counter stages driven by each controller.
  always @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n)                q_a <= '0;
    else if (!load_n_a)        q_a <= d_a;
    else if (enp_a && ent_a)   q_a <= q_a + 4'd1;
  end

  always @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n)                q_b <= '0;
    else if (!load_n_b)        q_b <= d_b;
    else if (enp_b && ent_b)   q_b <= q_b + 4'd1;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural model: an interval is LOAD, then (16 - preset) non-held
  // RUN cycles counted down arithmetically, then DONE.
  always @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      m_phase  <= P_IDLE;
      m_preset <= 0;
      m_pcnt   <= 0;
      m_rem    <= 0;
    end else begin
      case (m_phase)
        P_IDLE: if (start && !stop) begin
          m_phase  <= P_LOAD;
          m_preset <= int'(preset);
          m_pcnt   <= 0;
        end
        P_LOAD: if (stop) m_phase <= P_IDLE;
                else begin m_phase <= P_RUN; m_rem <= 16 - m_preset; end
        P_RUN: if (stop) m_phase <= P_IDLE;
               else if (!hold) begin
                 if (m_rem == 1) begin
                   m_phase <= P_DONE;
                   m_pcnt  <= m_pcnt + 1;
                 end
                 m_rem <= m_rem - 1;
               end
        default: m_phase <= (!stop && periodic) ? P_LOAD : P_IDLE;
      endcase
    end
  end

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge CLK) begin
    chk("busy",    int'(busy_a),   int'(m_phase != P_IDLE));
    chk("load_n",  int'(load_n_a), int'(m_phase != P_LOAD));
    chk("ent",     int'(ent_a),    int'(m_phase == P_RUN));
    chk("enp",     int'(enp_a),    int'(m_phase == P_RUN && !hold));
    chk("done",    int'(done_a),   int'(m_phase == P_DONE));
    chk("d",       int'(d_a),      m_preset);
    chk("pcnt",    int'(pcnt_a),   sat(m_pcnt, 255));
    chk("busy_w2", int'(busy_b),   int'(m_phase != P_IDLE));
    chk("done_w2", int'(done_b),   int'(m_phase == P_DONE));
    chk("pcnt_w2", int'(pcnt_b),   sat(m_pcnt, 3));
    if (done_a) begin
      if (n_done == 0) first_done = cyc;
      last_done = cyc;
      n_done++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy_a && k < bound) begin step(1); k++; end
    chk("wait_idle", int'(busy_a), 0);
  endtask

  task automatic wait_dones(input int n, input int bound);
    int k = 0;
    while (n_done < n && k < bound) begin step(1); k++; end
    chk("wait_dones", n_done, n);
  endtask

  task automatic go(input logic [3:0] p, input logic per);
    t0 = cyc; n_done = 0;
    start = 1'b1; preset = p; periodic = per;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 20000");
    $fatal(1);
  end

  initial begin
    CLR_n = 1'b0; start = 1'b0; stop = 1'b0; periodic = 1'b0; hold = 1'b0; preset = '0;
    n_done = 0; first_done = 0; last_done = 0;
    step(3);
    chk("rst_busy",   int'(busy_a),   0);
    chk("rst_load_n", int'(load_n_a), 1);
    chk("rst_pcnt",   int'(pcnt_a),   0);
    CLR_n = 1'b1;
    step(2);

    // One-shot, preset 10; preset change after acceptance must be ignored.
    go(4'd10, 1'b0);
    preset = 4'd3;
    chk("os_load_n", int'(load_n_a), 0);
    chk("os_d",      int'(d_a),      10);
    step(1);
    chk("os_q_first", int'(q_a), 10);
    wait_idle(40);
    chk("os_done_cyc", last_done, t0 + 8);
    chk("os_idle_cyc", cyc,       t0 + 9);
    chk("os_pcnt",     int'(pcnt_a), 1);

    // Back-to-back start in first IDLE cycle, periodic preset 13.
    go(4'd13, 1'b1);
    chk("b2b_load_n", int'(load_n_a), 0);
    wait_dones(4, 60);
    chk("per_first_done", first_done, t0 + 5);
    chk("per_last_done",  last_done,  t0 + 20);
    chk("per_pcnt4",      int'(pcnt_a), 4);
    step_to(t0 + 23);
    chk("per_in_run", int'(ent_a), 1);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("stop_busy", int'(busy_a), 0);
    chk("stop_pcnt", int'(pcnt_a), 4);
    step(10);
    chk("stop_no_done", n_done, 4);

    // Hold three cycles at Q=15, preset 14.
    go(4'd14, 1'b0);
    step_to(t0 + 3);
    chk("hold_q15", int'(q_a), 15);
    hold = 1'b1;
    step_to(t0 + 4);
    chk("hold_ent",  int'(ent_a),  1);
    chk("hold_enp",  int'(enp_a),  0);
    chk("hold_done", int'(done_a), 0);
    chk("hold_q",    int'(q_a),    15);
    step_to(t0 + 6);
    hold = 1'b0;
    wait_idle(20);
    chk("hold_done_cyc", last_done, t0 + 7);

    // Minimum interval, preset 15, plus narrow pcnt saturation and stop in DONE.
    go(4'd15, 1'b1);
    wait_dones(4, 40);
    chk("min_first_done", first_done, t0 + 3);
    chk("min_last_done",  last_done,  t0 + 12);
    step_to(t0 + 15);
    chk("min_done5",  int'(done_a), 1);
    chk("min_pcnt5",  int'(pcnt_a), 5);
    chk("sat_pcnt_w2", int'(pcnt_b), 3);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("stopdone_busy", int'(busy_a), 0);
    chk("stopdone_done", int'(done_a), 0);
    chk("stopdone_pcnt", int'(pcnt_a), 5);

    // preset 0 periodic; start/preset pulsed mid-RUN must not affect reload.
    go(4'd0, 1'b1);
    step_to(t0 + 6);
    start = 1'b1; preset = 4'd5;
    step(1);
    start = 1'b0;
    wait_dones(1, 40);
    chk("p0_first_done", first_done, t0 + 18);
    chk("p0_reload_n",   int'(load_n_a), 0);
    chk("p0_reload_d",   int'(d_a),      0);
    wait_dones(2, 40);
    chk("p0_second_done", last_done, t0 + 36);
    stop = 1'b1; step(1); stop = 1'b0;
    chk("p0_stop_busy", int'(busy_a), 0);

    // start and stop together in IDLE.
    start = 1'b1; stop = 1'b1; preset = 4'd9;
    step(1);
    start = 1'b0; stop = 1'b0;
    chk("ss_busy",   int'(busy_a),   0);
    chk("ss_load_n", int'(load_n_a), 1);
    step(1);
    chk("ss_busy2", int'(busy_a), 0);

    // Asynchronous reset mid-RUN after one completed interval.
    go(4'd14, 1'b1);
    step_to(t0 + 6);
    chk("ar_pcnt_pre", int'(pcnt_a), 1);
    chk("ar_in_run",   int'(ent_a),  1);
    #2 CLR_n = 1'b0;
    #1;
    chk("ar_busy",   int'(busy_a),   0);
    chk("ar_ent",    int'(ent_a),    0);
    chk("ar_enp",    int'(enp_a),    0);
    chk("ar_load_n", int'(load_n_a), 1);
    chk("ar_pcnt",   int'(pcnt_a),   0);
    chk("ar_d",      int'(d_a),      0);
    chk("ar_done",   int'(done_a),   0);
    step(2);
    CLR_n = 1'b1;
    step(3);
    chk("ar_post_busy", int'(busy_a), 0);
    chk("ar_post_pcnt", int'(pcnt_a), 0);
    chk("ar_post_done", n_done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Sequencing controller that sits directly upstream of the team's 4-bit synchronous presettable counter stage and drives its parallel-load and count-enable inputs. On a start request it latches a preset and loads it into the counter. It enables counting, watches the counter's Q bus for terminal count and reports completion. It then either stops (one-shot) or reloads and repeats (periodic), giving a programmable interval timer and clock divider.

## Interface
- CNT_W, 4: counter width; terminal count is Q = all ones.
- PCNT_W, 8: width of the completed-period counter.
- CLK  in  1  system clock; all state changes on rising edge.
- CLR_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE.
- stop  in  1  abort; sampled in every non-IDLE state; wins over start.
- periodic  in  1  1 = reload and repeat after terminal, 0 = one-shot; sampled in DONE.
- hold  in  1  pause counting while high (RUN only).
- preset  in  CNT_W  start value; latched when start is accepted.
- Q  in  CNT_W  counter stage output.
- D  out  CNT_W  parallel data to counter; equals latched preset.
- LOAD_n  out  1  active-low parallel load to counter.
- ENP  out  1  count enable parallel.
- ENT  out  1  count enable trickle.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse per completed interval.
- pcnt  out  PCNT_W  completed intervals since last start; saturates at all ones.

## Operation
- All outputs registered; decoded from next-state at each edge.
- States: IDLE, LOAD, RUN, DONE.
- Reset values: state IDLE, D=0, LOAD_n=1, ENP=0, ENT=0, busy=0, done=0, pcnt=0, latched preset=0.
- IDLE: start=1 and stop=0 -> LOAD; latch preset; clear pcnt.
- LOAD: LOAD_n=0, ENP=ENT=0, D=latched preset. Exits to RUN unconditionally unless stop.
- RUN: LOAD_n=1, ENT=1, ENP=~hold.
  - Terminal condition: Q == all ones AND hold == 0 -> DONE. Counter wraps to 0 on that same edge.
  - Q == all ones with hold=1: stay in RUN; no terminal.
- DONE: done=1, ENP=ENT=0, LOAD_n=1, pcnt += 1 (saturating).
  - periodic=1 -> LOAD; periodic=0 -> IDLE.
- stop=1 in LOAD/RUN/DONE -> IDLE next edge:
  - no done pulse is issued by the abort itself;
  - pcnt is retained;
  - a done already asserted in DONE still completes its single cycle.
- start while busy is ignored; preset changes while busy are ignored. Periodic reloads reuse the latched value.
- CLR_n low at any time, including mid-RUN: immediate return to reset values. The counter stage is cleared by its own reset.

## Timing
- Cycle 0: start sampled in IDLE. Cycle 1: LOAD (LOAD_n=0, busy=1). Cycle 2: RUN with Q=preset.
- RUN occupancy = (2^CNT_W − preset) cycles with hold never asserted. Each hold cycle adds one.
- done rises in cycle 2 + (2^CNT_W − preset) for the first interval.
- Periodic period = 2^CNT_W − preset + 2 cycles: LOAD + RUN + DONE. For CNT_W=4 this is 18 − preset.
- preset = all ones: RUN lasts exactly 1 cycle (minimum interval, period 3).
- One-shot: busy falls the cycle after DONE. IDLE is reached 3 + (16 − preset) cycles after start for CNT_W=4.
- Back-to-back: start re-asserted in the first IDLE cycle is accepted, so there is a 1-cycle IDLE gap.

## Test plan
- Reset: hold CLR_n=0 mid-RUN -> all outputs reset values in same cycle. After release, IDLE, pcnt=0, no done.
- One-shot, preset=4'd10, periodic=0 -> LOAD_n low in cycle 1, D=10. Six RUN cycles with Q 10..15. done in cycle 8, busy low from cycle 9, pcnt=1.
- Periodic, preset=4'd13 -> done every 5 cycles. After 4 intervals pcnt=4. stop in RUN -> IDLE next edge, no fifth done, pcnt stays 4.
- Hold: preset=4'd14, hold=1 for 3 cycles while Q=15 -> ENP=0, ENT=1, no DONE. done 3 cycles later than nominal.
- Edge values: preset=4'hF -> one RUN cycle, period 3. preset=0 -> 16 RUN cycles. pcnt with PCNT_W=2 saturates at 3 after 5 intervals.
- Contention: start and stop together in IDLE -> stays IDLE. preset changed and start pulsed mid-RUN -> ignored, D unchanged on next periodic reload.
